fsum_acc: RTL and testbench
===========================

Name: fsum_acc

Overview:
- Parametrised full-sum accumulator: the next generation of the single-lane output-sum stage after the conv MAC array.
- Each input beat carries LANES partial products for one output position. The block reduces them sequentially onto the stored partial sum for that position, or onto bias when the beat is the first input channel, and writes the result back.
- On the last input channel it emits the final value, with optional ReLU, through a valid/ready output and clears the entry.
- Sits between the MAC result FIFO and the output writeback FIFO.

Parameters:
- DW, 16: data width; signed two's complement.
- LANES, 8: lanes per input beat.
- DEPTH, 128: output positions held in the partial-sum buffer.
- IDXW, 7: index width; must satisfy 2^IDXW >= DEPTH.
- LCW, 4: lane-count width; must satisfy 2^LCW > LANES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  LANES*DW  lane i occupies bits [DW*i +: DW].
- in_lanes  in  LCW  active lanes, 1..LANES; 0 or >LANES is treated as LANES.
- in_index  in  IDXW  output position; index >= DEPTH is a dropped beat.
- in_first  in  1  first input channel: seed with bias.
- in_last  in  1  last input channel: emit and clear.
- bias  in  DW  bias for this output channel, sampled at accept.
- relu_en  in  1  apply ReLU on emit, sampled at accept.
- out_valid  out  1  final sum valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  final sum.
- out_index  out  IDXW  position of out_data.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=0, out_valid=0, out_data=0, out_index=0, ovf=0; all DEPTH buffer entries and internal counters 0. Reset mid-operation aborts the beat with no writeback.
- in_ready is 1 only in IDLE and only when rst_n is high. A beat is accepted when in_valid & in_ready.
- IDLE, on accept:
  - capture in_data, effective lane count n, index, first/last flags, relu_en;
  - acc <= in_first ? bias : buf[in_index] (combinational buffer read);
  - lane_cnt <= 0; go to ACC.
  - If in_index >= DEPTH: the beat is consumed, nothing is written or emitted, stay IDLE.
- ACC: each cycle acc <= sat(acc + lane[lane_cnt]) and lane_cnt++. After lane n-1, go to WRITE. Occupies exactly n cycles.
- sat(): DW+1-bit signed sum clamped to [-(2^(DW-1)), 2^(DW-1)-1]. Any clamp sets ovf. Lanes >= n are ignored.
- WRITE, one cycle:
  - not last: buf[idx] <= acc; go to IDLE.
  - last: buf[idx] <= 0; out_data <= (relu & acc<0) ? 0 : acc; out_index <= idx; out_valid <= 1; go to EMIT.
- EMIT: out_valid, out_data and out_index are held stable until out_ready is seen. On out_valid & out_ready, out_valid <= 0 and go to IDLE (in_ready=1 next cycle).
- Timing: accept at edge t gives ACC over t+1..t+n, WRITE at t+n+1, and out_valid high from t+n+2. For a non-last beat, in_ready is high again at t+n+2.
- Both in_first and in_last set: single-channel case, bias + lanes, emitted directly.
- in_first with a non-zero stored entry: the stored value is discarded (overwritten).
- ovf_clr with a saturation in the same cycle: set wins.
- Back-to-back beats to the same index are safe; the FSM serialises read-modify-write.

Decomposition:
- Shared package constants: DW, LANES, MAX_O_SIDE (=DEPTH), BURST_LEN (=LANES); state encoding IDLE/ACC/WRITE/EMIT as localparams.
- Sub-module sat_add (DW-parametrised combinational saturating adder with overflow output), instantiated once.

Test Plan (DW=16, LANES=4, DEPTH=128):
- Single channel: first=last=1, idx=3, bias=10, lanes {1,2,3,4}, n=4, out_ready=1 -> out_valid at t+6, out_data=20, out_index=3, buf[3]=0, ovf=0.
- Two channels, idx=5: first beat bias=7, lanes all 1 (not last); then last beat lanes all 2 -> no output after first beat; out_data=19 after second beat.
- Saturation: bias=0x7FF0, lanes 0x0010 x4, first=last=1 -> out_data=0x7FFF, ovf=1; ovf_clr pulse -> ovf=0.
- ReLU: bias=-100, lanes 0, first=last=1; relu_en=1 -> out_data=0; relu_en=0 -> out_data=0xFF9C.
- Partial lanes plus backpressure: in_lanes=2, lanes {5,6,99,99}, bias=0, out_ready low 5 cycles -> out_data=11 held stable with in_ready=0; after the out_ready handshake, in_ready=1 next cycle.
- Reset mid-ACC: drop rst_n during lane 2 -> all outputs 0 immediately; after release a subsequent non-first beat to the same idx reads 0 from the buffer.

Source files
------------

// File: rtl/fsum_acc_pkg.sv
// fsum_acc_pkg: shared constants and types for the full-sum accumulator.
//   DW          default data width (signed two's complement)
//   LANES       default partial products per input beat
//   MAX_O_SIDE  default number of output positions in the partial-sum buffer
//   BURST_LEN   lanes reduced per beat (same as LANES)
//   state_e     control FSM states
package fsum_acc_pkg;

   localparam int unsigned DW         = 16;
   localparam int unsigned LANES      = 8;
   localparam int unsigned MAX_O_SIDE = 128;
   localparam int unsigned BURST_LEN  = LANES;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_WRITE = 2'd2,
      ST_EMIT  = 2'd3
   } state_e;

endpackage

// File: rtl/fsum_acc_sat_add.sv
// sat_add: combinational signed saturating adder.
//   a_i, b_i  DW-bit signed operands
//   sum_o     a_i + b_i clamped to [-(2^(DW-1)), 2^(DW-1)-1]
//   ovf_o     high when the clamp was applied
module sat_add #(
   parameter int unsigned DW = fsum_acc_pkg::DW
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] sum_o,
   output logic          ovf_o
);

   import fsum_acc_pkg::*;

   logic [DW:0] sum_x;

   assign sum_x = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};

   // The DW+1-bit result fits in DW bits only when its top two bits agree.
   assign ovf_o = sum_x[DW] ^ sum_x[DW-1];

   always_comb begin
      sum_o = sum_x[DW-1:0];
      if (ovf_o) begin
         sum_o = sum_x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/fsum_acc.sv
// fsum_acc: full-sum accumulator between the MAC result FIFO and the output
// writeback FIFO. Each beat's active lanes are added one per cycle onto either
// the bias (first input channel) or the stored partial sum for that position;
// the result is written back, or on the last channel emitted (optional ReLU)
// and the entry cleared.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_data             LANES x DW partial products, lane i at [DW*i +: DW]
//   in_lanes            active lane count (0 or >LANES means LANES)
//   in_index            output position (>= DEPTH drops the beat)
//   in_first, in_last   first / last input channel flags
//   bias, relu_en       sampled at accept
//   out_valid/out_ready final-sum handshake
//   out_data, out_index final sum and its position
//   ovf, ovf_clr        sticky saturation flag and its synchronous clear
module fsum_acc #(
   parameter int unsigned DW    = fsum_acc_pkg::DW,
   parameter int unsigned LANES = fsum_acc_pkg::BURST_LEN,
   parameter int unsigned DEPTH = fsum_acc_pkg::MAX_O_SIDE,
   parameter int unsigned IDXW  = 7,
   parameter int unsigned LCW   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*DW-1:0] in_data,
   input  logic [LCW-1:0]      in_lanes,
   input  logic [IDXW-1:0]     in_index,
   input  logic                in_first,
   input  logic                in_last,
   input  logic [DW-1:0]       bias,
   input  logic                relu_en,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW-1:0]       out_data,
   output logic [IDXW-1:0]     out_index,
   output logic                ovf,
   input  logic                ovf_clr
);

   import fsum_acc_pkg::*;

   state_e               state_q, state_d;
   logic [DW-1:0]        acc_q, acc_d;
   logic [LCW-1:0]       lane_cnt_q, lane_cnt_d;
   logic [LCW-1:0]       n_q, n_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic                 last_q, last_d;
   logic                 relu_q, relu_d;
   logic [LANES*DW-1:0]  data_q, data_d;
   logic                 out_valid_q, out_valid_d;
   logic [DW-1:0]        out_data_q, out_data_d;
   logic [IDXW-1:0]      out_index_q, out_index_d;
   logic                 ovf_q, ovf_d;

   logic [DW-1:0]        psum_q [DEPTH];
   logic [DW-1:0]        psum_rd;
   logic                 psum_we;

   logic                 accept;
   logic                 idx_ok;
   logic [LCW-1:0]       lanes_eff;
   logic [DW-1:0]        lane_val;
   logic [DW-1:0]        sat_sum;
   logic                 sat_ovf;
   logic                 ovf_set;

   // Out-of-range indices are only possible when DEPTH < 2^IDXW.
   if (DEPTH >= (1 << IDXW)) begin : g_idx_full
      assign idx_ok = 1'b1;
   end else begin : g_idx_part
      assign idx_ok = (in_index < IDXW'(DEPTH));
   end

   assign accept    = in_valid & in_ready;
   assign lanes_eff = ((in_lanes == '0) || (in_lanes > LCW'(LANES))) ? LCW'(LANES) : in_lanes;
   assign psum_rd   = psum_q[in_index];
   assign lane_val  = DW'(data_q >> (32'(lane_cnt_q) * DW));
   assign ovf_set   = (state_q == ST_ACC) && sat_ovf;

   sat_add #(
      .DW(DW)
   ) u_sat_add (
      .a_i  (acc_q),
      .b_i  (lane_val),
      .sum_o(sat_sum),
      .ovf_o(sat_ovf)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept && idx_ok) state_d = ST_ACC;
         ST_ACC:   if (lane_cnt_q == (n_q - 1'b1)) state_d = ST_WRITE;
         ST_WRITE: state_d = last_q ? ST_EMIT : ST_IDLE;
         ST_EMIT:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (state_q == ST_IDLE) && rst_n;
      psum_we  = (state_q == ST_WRITE);
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      acc_d       = acc_q;
      lane_cnt_d  = lane_cnt_q;
      n_d         = n_q;
      idx_d       = idx_q;
      last_d      = last_q;
      relu_d      = relu_q;
      data_d      = data_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;

      case (state_q)
         ST_IDLE: begin
            if (accept && idx_ok) begin
               data_d     = in_data;
               n_d        = lanes_eff;
               idx_d      = in_index;
               last_d     = in_last;
               relu_d     = relu_en;
               acc_d      = in_first ? bias : psum_rd;
               lane_cnt_d = '0;
            end
         end
         ST_ACC: begin
            acc_d      = sat_sum;
            lane_cnt_d = lane_cnt_q + 1'b1;
         end
         ST_WRITE: begin
            if (last_q) begin
               out_data_d  = (relu_q && acc_q[DW-1]) ? '0 : acc_q;
               out_index_d = idx_q;
               out_valid_d = 1'b1;
            end
         end
         ST_EMIT: begin
            if (out_ready) out_valid_d = 1'b0;
         end
         default: ;
      endcase

      // A saturation in the same cycle as a clear keeps the flag set.
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         lane_cnt_q  <= '0;
         n_q         <= '0;
         idx_q       <= '0;
         last_q      <= 1'b0;
         relu_q      <= 1'b0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         lane_cnt_q  <= lane_cnt_d;
         n_q         <= n_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         relu_q      <= relu_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         ovf_q       <= ovf_d;
      end
   end

   // Partial-sum buffer: the last channel clears its entry for the next tile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            psum_q[i] <= '0;
         end
      end else if (psum_we) begin
         psum_q[idx_q] <= last_q ? '0 : acc_q;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fsum_acc.sv
// tb_fsum_acc: directed self-checking bench for fsum_acc (DW=16, LANES=4,
// DEPTH=128) with hand-computed expected sums and latencies.
module tb_fsum_acc;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [3:0]  in_lanes;
   logic [6:0]  in_index;
   logic        in_first;
   logic        in_last;
   logic [15:0] bias;
   logic        relu_en;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [6:0]  out_index;
   logic        ovf;
   logic        ovf_clr;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   fsum_acc #(
      .DW   (16),
      .LANES(4),
      .DEPTH(128),
      .IDXW (7),
      .LCW  (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_lanes (in_lanes),
      .in_index (in_index),
      .in_first (in_first),
      .in_last  (in_last),
      .bias     (bias),
      .relu_en  (relu_en),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_index(out_index),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one beat at a negedge once in_ready is up; returns 1ns after the accepting edge.
   task automatic send(input logic first, input logic last, input logic [6:0] idx,
                       input logic [15:0] b, input logic relu, input logic [3:0] nl,
                       input logic [63:0] d);
      int unsigned w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check_val("accept_wait", 32'(in_ready), 32'd1);
      in_first = first;
      in_last  = last;
      in_index = idx;
      bias     = b;
      relu_en  = relu;
      in_lanes = nl;
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts edges until out_valid is seen at a negedge.
   task automatic wait_out(input int unsigned lat, input string tag);
      int unsigned cyc = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else cyc++;
      end
      check_val({tag, "_lat"}, cyc, lat);
   endtask

   // Counts edges until in_ready returns; out_valid must stay low meanwhile.
   task automatic wait_ready(input int unsigned lat, input string tag);
      int unsigned cyc = 0;
      bit seen = 1'b0;
      bit ov = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) ov = 1'b1;
         if (in_ready) seen = 1'b1;
         else cyc++;
      end
      check_val({tag, "_rdy_lat"}, cyc, lat);
      check_val({tag, "_no_out"}, 32'(ov), 32'd0);
   endtask

   // With out_ready high, the handshake completes on the next edge.
   task automatic finish_out(input string tag);
      @(posedge clk);
      #1;
      check_val({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      check_val({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic pulse_clr(input string tag);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      check_val(tag, 32'(ovf), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_lanes  = '0;
      in_index  = '0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      bias      = '0;
      relu_en   = 1'b0;
      out_ready = 1'b1;
      ovf_clr   = 1'b0;

      #2 rst_n = 1'b0;
      #20;
      check_val("rst_in_ready",  32'(in_ready),  32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data",  32'(out_data),  32'd0);
      check_val("rst_out_index", 32'(out_index), 32'd0);
      check_val("rst_ovf",       32'(ovf),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_val("rst_rel_ready", 32'(in_ready), 32'd1);

      // Single channel: 10 + 1+2+3+4 = 20
      send(1, 1, 7'd3, 16'd10, 0, 4'd4, {16'd4, 16'd3, 16'd2, 16'd1});
      wait_out(5, "single");
      check_val("single_data", 32'(out_data),  32'd20);
      check_val("single_idx",  32'(out_index), 32'd3);
      check_val("single_ovf",  32'(ovf),       32'd0);
      finish_out("single");
      // Entry 3 was cleared: non-first last beat with zero lanes yields 0
      send(0, 1, 7'd3, 16'd555, 0, 4'd4, 64'd0);
      wait_out(5, "clr3");
      check_val("clr3_data", 32'(out_data), 32'd0);
      finish_out("clr3");

      // Two channels on index 5: 7+4 stored, then +8 -> 19
      send(1, 0, 7'd5, 16'd7, 0, 4'd4, {16'd1, 16'd1, 16'd1, 16'd1});
      wait_ready(5, "ch1");
      send(0, 1, 7'd5, 16'd999, 0, 4'd4, {16'd2, 16'd2, 16'd2, 16'd2});
      wait_out(5, "ch2");
      check_val("ch2_data", 32'(out_data),  32'd19);
      check_val("ch2_idx",  32'(out_index), 32'd5);
      finish_out("ch2");

      // Positive saturation: 0x7FF0 + 4*0x10 clamps at 0x7FFF
      send(1, 1, 7'd10, 16'h7FF0, 0, 4'd4, {16'h0010, 16'h0010, 16'h0010, 16'h0010});
      wait_out(5, "psat");
      check_val("psat_data", 32'(out_data), 32'h7FFF);
      check_val("psat_ovf",  32'(ovf),      32'd1);
      finish_out("psat");
      pulse_clr("psat_clr");

      // Clear held high while saturating: the set must win
      ovf_clr = 1'b1;
      send(1, 1, 7'd11, 16'h7FF0, 0, 4'd4, {16'h0010, 16'h0010, 16'h0010, 16'h0010});
      @(negedge clk);
      @(negedge clk);
      check_val("set_wins", 32'(ovf), 32'd1);
      ovf_clr = 1'b0;
      wait_out(3, "setw");
      check_val("setw_data", 32'(out_data), 32'h7FFF);
      finish_out("setw");
      pulse_clr("setw_clr");

      // Negative saturation: 0x8000 + 4*(-1) clamps at 0x8000
      send(1, 1, 7'd12, 16'h8000, 0, 4'd4, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      wait_out(5, "nsat");
      check_val("nsat_data", 32'(out_data), 32'h8000);
      check_val("nsat_ovf",  32'(ovf),      32'd1);
      finish_out("nsat");
      pulse_clr("nsat_clr");

      // ReLU on -100, without ReLU, and ReLU on a positive value
      send(1, 1, 7'd20, 16'hFF9C, 1, 4'd4, 64'd0);
      wait_out(5, "relu1");
      check_val("relu1_data", 32'(out_data), 32'd0);
      finish_out("relu1");
      send(1, 1, 7'd20, 16'hFF9C, 0, 4'd4, 64'd0);
      wait_out(5, "relu0");
      check_val("relu0_data", 32'(out_data), 32'hFF9C);
      finish_out("relu0");
      send(1, 1, 7'd21, 16'd5, 1, 4'd4, 64'd0);
      wait_out(5, "relup");
      check_val("relup_data", 32'(out_data), 32'd5);
      finish_out("relup");

      // in_first discards a non-zero stored entry: 100 stored, then 1+1 -> 2
      send(1, 0, 7'd40, 16'd100, 0, 4'd4, 64'd0);
      wait_ready(5, "ow1");
      send(1, 1, 7'd40, 16'd1, 0, 4'd4, {16'd0, 16'd0, 16'd0, 16'd1});
      wait_out(5, "ow2");
      check_val("ow2_data", 32'(out_data), 32'd2);
      finish_out("ow2");

      // Two active lanes with backpressure: 5+6 = 11, lanes 2..3 ignored
      out_ready = 1'b0;
      send(1, 1, 7'd30, 16'd0, 0, 4'd2, {16'd99, 16'd99, 16'd6, 16'd5});
      wait_out(3, "bp");
      for (int i = 0; i < 5; i++) begin
         check_val("bp_data",  32'(out_data),  32'd11);
         check_val("bp_idx",   32'(out_index), 32'd30);
         check_val("bp_vld",   32'(out_valid), 32'd1);
         check_val("bp_rdy",   32'(in_ready),  32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      finish_out("bp");

      // in_lanes = 0 and in_lanes > LANES both mean all four lanes
      send(1, 1, 7'd31, 16'd0, 0, 4'd0, {16'd4, 16'd3, 16'd2, 16'd1});
      wait_out(5, "ln0");
      check_val("ln0_data", 32'(out_data), 32'd10);
      finish_out("ln0");
      send(1, 1, 7'd32, 16'd0, 0, 4'd7, {16'd4, 16'd3, 16'd2, 16'd1});
      wait_out(5, "ln7");
      check_val("ln7_data", 32'(out_data), 32'd10);
      finish_out("ln7");

      // Reset during lane 2 of a second-channel beat on index 9 (54 stored)
      send(1, 0, 7'd9, 16'd50, 0, 4'd4, {16'd1, 16'd1, 16'd1, 16'd1});
      wait_ready(5, "rm1");
      send(0, 0, 7'd9, 16'd0, 0, 4'd4, {16'd1, 16'd1, 16'd1, 16'd1});
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("rm_out_valid", 32'(out_valid), 32'd0);
      check_val("rm_out_data",  32'(out_data),  32'd0);
      check_val("rm_out_index", 32'(out_index), 32'd0);
      check_val("rm_in_ready",  32'(in_ready),  32'd0);
      check_val("rm_ovf",       32'(ovf),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(0, 1, 7'd9, 16'd0, 0, 4'd4, 64'd0);
      wait_out(5, "rm2");
      check_val("rm2_data", 32'(out_data),  32'd0);
      check_val("rm2_idx",  32'(out_index), 32'd9);
      finish_out("rm2");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
